// File: rtl/mult_div_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mult_div_pkg
//  Description : Shared types and sizing helpers for the mult_div unit.
//  Revision    : 1.0 - initial release
// ============================================================================
package mult_div_pkg;

    localparam int LARGURA_PADRAO = 32;

    typedef enum logic [1:0] {
        OCIOSO = 2'd0,
        MULT   = 2'd1,
        DIV    = 2'd2,
        FIM    = 2'd3
    } estado_t;

    function automatic int largura_cnt(input int largura);
        return $clog2(largura + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/div_passo.sv
`default_nettype none
// ============================================================================
//  Module      : div_passo
//  Description : One combinational restoring-division step on magnitudes.
//  Revision    : 1.0 - initial release
// ============================================================================
module div_passo #(
    parameter int LARGURA = 32
) (
    input  logic [LARGURA-1:0] resto,
    input  logic               bit_dividendo,
    input  logic [LARGURA-1:0] divisor,
    output logic [LARGURA-1:0] resto_prox,
    output logic               bit_quociente
);

    logic [LARGURA:0] w_desl;
    logic [LARGURA:0] w_tent;

    assign w_desl = {resto, bit_dividendo};

    // resto < divisor keeps the trial result within +/-2^LARGURA, so the top
    // bit of an LARGURA+1 wide difference is a faithful sign bit.
    assign w_tent = w_desl - {1'b0, divisor};

    assign bit_quociente = ~w_tent[LARGURA];
    assign resto_prox    = w_tent[LARGURA] ? w_desl[LARGURA-1:0] : w_tent[LARGURA-1:0];

endmodule
`default_nettype wire

// File: rtl/mult_div.sv
`default_nettype none
// ============================================================================
//  Module      : mult_div
//  Description : Iterative signed Booth multiply / restoring divide into HI/LO.
//  Revision    : 1.0 - initial release
// ============================================================================
module mult_div
    import mult_div_pkg::*;
#(
    parameter int LARGURA = LARGURA_PADRAO
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               iniciar_mult,
    input  logic               iniciar_div,
    input  logic [LARGURA-1:0] a,
    input  logic [LARGURA-1:0] b,
    output logic [LARGURA-1:0] hi,
    output logic [LARGURA-1:0] lo,
    output logic               ocupado,
    output logic               pronto,
    output logic               div_zero
);

    localparam int CW = largura_cnt(LARGURA);

    estado_t            r_estado;
    estado_t            w_prox;
    logic [CW-1:0]      r_cnt;
    logic [LARGURA:0]   r_acc;
    logic [LARGURA-1:0] r_q;
    logic               r_q1;
    logic [LARGURA-1:0] r_m;
    logic [LARGURA-1:0] r_resto;
    logic               r_neg_q;
    logic               r_neg_r;
    logic [LARGURA-1:0] r_hi;
    logic [LARGURA-1:0] r_lo;
    logic               r_div_zero;

    logic               w_aceita_mult;
    logic               w_aceita_div;
    logic               w_rejeita;
    logic               w_ultimo;
    logic [LARGURA:0]   w_m_ext;
    logic [LARGURA:0]   w_soma;
    logic [LARGURA:0]   w_acc_prox;
    logic [LARGURA-1:0] w_q_mult;
    logic [LARGURA-1:0] w_mag_a;
    logic [LARGURA-1:0] w_mag_b;
    logic [LARGURA-1:0] w_resto_prox;
    logic               w_bit_q;
    logic [LARGURA-1:0] w_quo;
    logic [LARGURA-1:0] w_quo_final;
    logic [LARGURA-1:0] w_resto_final;

    assign w_aceita_mult = (r_estado == OCIOSO) && iniciar_mult;
    assign w_aceita_div  = (r_estado == OCIOSO) && !iniciar_mult && iniciar_div && (b != '0);
    assign w_rejeita     = (r_estado == OCIOSO) && !iniciar_mult && iniciar_div && (b == '0);
    assign w_ultimo      = (r_cnt == CW'(LARGURA - 1));

    // Booth step: the 33-bit accumulator absorbs -(-2^31) without overflow.
    assign w_m_ext = {r_m[LARGURA-1], r_m};

    always_comb begin
        w_soma = r_acc;
        case ({r_q[0], r_q1})
            2'b01:   w_soma = r_acc + w_m_ext;
            2'b10:   w_soma = r_acc - w_m_ext;
            default: w_soma = r_acc;
        endcase
    end

    assign w_acc_prox = {w_soma[LARGURA], w_soma[LARGURA:1]};
    assign w_q_mult   = {w_soma[0], r_q[LARGURA-1:1]};

    assign w_mag_a = a[LARGURA-1] ? -a : a;
    assign w_mag_b = b[LARGURA-1] ? -b : b;

    div_passo #(
        .LARGURA (LARGURA)
    ) u_div_passo (
        .resto         (r_resto),
        .bit_dividendo (r_q[LARGURA-1]),
        .divisor       (r_m),
        .resto_prox    (w_resto_prox),
        .bit_quociente (w_bit_q)
    );

    assign w_quo         = {r_q[LARGURA-2:0], w_bit_q};
    assign w_quo_final   = r_neg_q ? -w_quo : w_quo;
    assign w_resto_final = r_neg_r ? -w_resto_prox : w_resto_prox;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_estado <= OCIOSO;
        end else begin
            r_estado <= w_prox;
        end
    end

    always_comb begin
        w_prox = r_estado;
        case (r_estado)
            OCIOSO: begin
                if (w_aceita_mult)     w_prox = MULT;
                else if (w_aceita_div) w_prox = DIV;
            end
            MULT:    if (w_ultimo) w_prox = FIM;
            DIV:     if (w_ultimo) w_prox = FIM;
            FIM:     w_prox = OCIOSO;
            default: w_prox = OCIOSO;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt      <= '0;
            r_acc      <= '0;
            r_q        <= '0;
            r_q1       <= 1'b0;
            r_m        <= '0;
            r_resto    <= '0;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
            r_hi       <= '0;
            r_lo       <= '0;
            r_div_zero <= 1'b0;
        end else begin
            r_div_zero <= w_rejeita;
            case (r_estado)
                OCIOSO: begin
                    if (w_aceita_mult) begin
                        r_acc <= '0;
                        r_q   <= a;
                        r_q1  <= 1'b0;
                        r_m   <= b;
                        r_cnt <= '0;
                    end else if (w_aceita_div) begin
                        r_resto <= '0;
                        r_q     <= w_mag_a;
                        r_m     <= w_mag_b;
                        r_neg_q <= a[LARGURA-1] ^ b[LARGURA-1];
                        r_neg_r <= a[LARGURA-1];
                        r_cnt   <= '0;
                    end
                end
                MULT: begin
                    r_acc <= w_acc_prox;
                    r_q   <= w_q_mult;
                    r_q1  <= r_q[0];
                    r_cnt <= r_cnt + CW'(1);
                    if (w_ultimo) begin
                        r_hi <= w_acc_prox[LARGURA-1:0];
                        r_lo <= w_q_mult;
                    end
                end
                DIV: begin
                    r_resto <= w_resto_prox;
                    r_q     <= w_quo;
                    r_cnt   <= r_cnt + CW'(1);
                    if (w_ultimo) begin
                        r_hi <= w_resto_final;
                        r_lo <= w_quo_final;
                    end
                end
                default: ;
            endcase
        end
    end

    assign hi       = r_hi;
    assign lo       = r_lo;
    assign ocupado  = (r_estado != OCIOSO);
    assign pronto   = (r_estado == FIM);
    assign div_zero = r_div_zero;

endmodule
`default_nettype wire

// File: tb/tb_mult_div.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mult_div
//  Description : Self-checking bench for mult_div against an arithmetic model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mult_div;

    logic        clk;
    logic        reset_n;
    logic        iniciar_mult;
    logic        iniciar_div;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        ocupado;
    logic        pronto;
    logic        div_zero;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] model_hi = '0;
    logic [31:0] model_lo = '0;

    mult_div #(
        .LARGURA (32)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .iniciar_mult (iniciar_mult),
        .iniciar_div  (iniciar_div),
        .a            (a),
        .b            (b),
        .hi           (hi),
        .lo           (lo),
        .ocupado      (ocupado),
        .pronto       (pronto),
        .div_zero     (div_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic verifica(input string tag, input logic [63:0] obs, input logic [63:0] esp);
        n_checks++;
        if (obs !== esp) begin
            n_errors++;
            $display("FAIL %s obs=%h exp=%h", tag, obs, esp);
        end
    endtask

    // Reference: signed 64-bit arithmetic; SV '/' truncates toward zero and
    // '%' follows the dividend sign, which is exactly the required behaviour.
    function automatic logic [63:0] modelo(input bit is_mult, input logic [31:0] va, input logic [31:0] vb);
        longint sa, sb, p, q, r;
        sa = longint'($signed(va));
        sb = longint'($signed(vb));
        if (is_mult) begin
            p = sa * sb;
            return p;
        end
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    task automatic run_op(input bit sm, input bit sd, input logic [31:0] va, input logic [31:0] vb, input int inj);
        logic [63:0] esp;
        int lat;
        int busy;
        esp = modelo(sm, va, vb);
        @(posedge clk); #1;
        verifica("idle_pronto", 64'(pronto), 64'd0);
        verifica("idle_ocupado", 64'(ocupado), 64'd0);
        iniciar_mult = sm;
        iniciar_div  = sd;
        a = va;
        b = vb;
        @(posedge clk); #1;
        iniciar_mult = 1'b0;
        iniciar_div  = 1'b0;
        a = $urandom;
        b = $urandom;
        lat  = 1;
        busy = 0;
        while (!pronto && lat < 100) begin
            if (ocupado) busy++;
            iniciar_div = (lat == inj);
            @(posedge clk); #1;
            lat++;
        end
        iniciar_div = 1'b0;
        if (ocupado) busy++;
        verifica("latencia", 64'(lat), 64'd33);
        verifica("ocupado_ciclos", 64'(busy), 64'(lat));
        verifica("hi", 64'(hi), 64'(esp[63:32]));
        verifica("lo", 64'(lo), 64'(esp[31:0]));
        model_hi = esp[63:32];
        model_lo = esp[31:0];
    endtask

    task automatic div_por_zero(input logic [31:0] va);
        @(posedge clk); #1;
        iniciar_mult = 1'b0;
        iniciar_div  = 1'b1;
        a = va;
        b = '0;
        @(posedge clk); #1;
        iniciar_div = 1'b0;
        verifica("dz_pulso", 64'(div_zero), 64'd1);
        verifica("dz_ocupado", 64'(ocupado), 64'd0);
        verifica("dz_pronto", 64'(pronto), 64'd0);
        verifica("dz_hi", 64'(hi), 64'(model_hi));
        verifica("dz_lo", 64'(lo), 64'(model_lo));
        @(posedge clk); #1;
        verifica("dz_fim", 64'(div_zero), 64'd0);
        verifica("dz_ocupado2", 64'(ocupado), 64'd0);
    endtask

    initial begin
        reset_n      = 1'b0;
        iniciar_mult = 1'b0;
        iniciar_div  = 1'b0;
        a            = '0;
        b            = '0;
        repeat (3) @(posedge clk);
        #1;
        verifica("rst_hi", 64'(hi), 64'd0);
        verifica("rst_lo", 64'(lo), 64'd0);
        verifica("rst_ocupado", 64'(ocupado), 64'd0);
        verifica("rst_pronto", 64'(pronto), 64'd0);
        verifica("rst_div_zero", 64'(div_zero), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;

        run_op(1'b1, 1'b0, 32'd7, 32'hFFFF_FFFD, 0);
        run_op(1'b1, 1'b0, 32'h8000_0000, 32'h8000_0000, 0);
        run_op(1'b0, 1'b1, 32'd100, 32'hFFFF_FFF9, 0);
        run_op(1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2, 0);
        run_op(1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        div_por_zero(32'd5);
        run_op(1'b1, 1'b1, 32'd123456, 32'hFFFF_FF9D, 0);

        // A divide start mid-multiply must be dropped, not queued.
        run_op(1'b1, 1'b0, $urandom, $urandom, 10);
        repeat (3) begin
            @(posedge clk); #1;
            verifica("ignorado_pronto", 64'(pronto), 64'd0);
            verifica("ignorado_ocupado", 64'(ocupado), 64'd0);
        end

        // Asynchronous reset in the middle of a divide.
        @(posedge clk); #1;
        iniciar_div = 1'b1;
        a = 32'd1000;
        b = 32'd7;
        @(posedge clk); #1;
        iniciar_div = 1'b0;
        repeat (11) @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        verifica("rst_meio_hi", 64'(hi), 64'd0);
        verifica("rst_meio_lo", 64'(lo), 64'd0);
        verifica("rst_meio_ocupado", 64'(ocupado), 64'd0);
        model_hi = '0;
        model_lo = '0;
        @(negedge clk);
        reset_n = 1'b1;
        run_op(1'b1, 1'b0, 32'd3, 32'd4, 0);

        for (int i = 0; i < 24; i++) begin
            bit          sm;
            logic [31:0] va;
            logic [31:0] vb;
            sm = bit'($urandom_range(0, 1));
            va = $urandom;
            case ($urandom_range(0, 3))
                0:       vb = $urandom;
                1:       vb = 32'($urandom_range(0, 15));
                2:       vb = -32'($urandom_range(0, 15));
                default: vb = ($urandom_range(0, 1) != 0) ? 32'h8000_0000 : 32'hFFFF_FFFF;
            endcase
            if (!sm && vb == '0) div_por_zero(va);
            else                 run_op(sm, !sm, va, vb, 0);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mult_div.md
Name: mult_div

Overview:
- Sequential signed multiply/divide unit for the multicycle datapath.
- Results go to the HI/LO registers, and those registers feed inputs of the 7-way 32-bit write-back select mux.
- The control unit starts an operation with a one-cycle pulse, waits for `pronto`, then steers HI or LO through the mux (mfhi/mflo).
- Multiply is radix-2 Booth; divide is restoring. Both are iterative, one bit per cycle.

Parameters:
- LARGURA, 32, operand/result width. Iteration count equals LARGURA.

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- iniciar_mult  input  1  start signed multiply (sampled only in OCIOSO).
- iniciar_div  input  1  start signed divide (sampled only in OCIOSO).
- a  input  LARGURA  operand A / dividend.
- b  input  LARGURA  operand B / divisor.
- hi  output  LARGURA  mult: product[63:32]; div: remainder.
- lo  output  LARGURA  mult: product[31:0]; div: quotient.
- ocupado  output  1  operation in progress.
- pronto  output  1  one-cycle pulse: hi/lo just updated.
- div_zero  output  1  one-cycle pulse: divide by zero rejected.

Behaviour:
- Reset (async, reset_n=0):
  - State goes to OCIOSO.
  - hi, lo, internal accumulators and counter all clear to 0.
  - ocupado, pronto and div_zero are 0.
  - Reset during an operation aborts it; no partial result is ever written.
- States: OCIOSO, MULT, DIV, FIM.
- OCIOSO, at a clock edge:
  - iniciar_mult=1: capture a and b, clear the counter, go to MULT. iniciar_mult has priority if both starts are high.
  - Otherwise iniciar_div=1 and b!=0: capture a and b, record operand signs, take magnitudes, go to DIV.
  - Otherwise iniciar_div=1 and b==0: stay in OCIOSO, pulse div_zero for the next cycle, leave hi/lo unchanged, keep ocupado=0.
- MULT:
  - One Booth step per cycle, using the pair {Q[0], Q-1}.
  - Add/sub B into the 33-bit upper accumulator, then arithmetic-shift right.
  - After LARGURA steps, go to FIM.
- DIV:
  - One restoring step per cycle on the magnitudes: shift, trial-subtract, restore if negative.
  - After LARGURA steps, apply signs and go to FIM.
  - Quotient truncates toward zero; it is negated if the operand signs differ.
  - Remainder takes the sign of the dividend.
- On the edge entering FIM, hi/lo load the result.
- FIM: pronto=1 for exactly one cycle, then return to OCIOSO.
- ocupado=1 in MULT, DIV and FIM.
- Latency: start high in cycle 0 gives pronto=1 and the new hi/lo in cycle LARGURA+1 (cycle 33 by default).
- Starts asserted while ocupado=1 are ignored; they are not queued.
- A start is accepted in the cycle after FIM; the unit supports back-to-back operations.
- Width rules:
  - Product is the full 64-bit signed result; no overflow is possible.
  - Overflow case 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0 (wrap, no flag).
- Between operations, hi and lo hold their values. Operands changing after acceptance have no effect.

Decomposition:
- Package mult_div_pkg holds:
  - typedef enum estado_t {OCIOSO, MULT, DIV, FIM};
  - constant LARGURA_PADRAO = 32;
  - the counter width derivation, $clog2(LARGURA+1).
- One natural sub-module, div_passo: combinational single restoring-division step.
  - Inputs: partial remainder, dividend bit, divisor.
  - Outputs: next remainder, quotient bit.
- The Booth step stays inline.

Test Plan:
1. Multiply: iniciar_mult, a=7, b=0xFFFFFFFD (-3) -> pronto in cycle 33, hi=0xFFFFFFFF, lo=0xFFFFFFEB; ocupado=1 in cycles 1..33.
2. Multiply extreme: a=b=0x80000000 -> hi=0x40000000, lo=0x00000000.
3. Divide signs:
   - a=100, b=-7 -> lo=0xFFFFFFF2 (-14), hi=2.
   - a=-7, b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
   - a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
4. Divide by zero, with hi/lo holding a prior result: a=5, b=0 -> div_zero=1 for one cycle, ocupado stays 0, pronto stays 0, hi/lo unchanged.
5. Busy/priority:
   - iniciar_mult and iniciar_div high together -> multiply result.
   - iniciar_div pulsed in cycle 10 of a multiply -> ignored, only one pronto.
   - New start in the cycle after pronto -> accepted.
6. Reset mid-op: reset_n low in cycle 12 of a divide -> hi=lo=0, ocupado=0 immediately (asynchronous). A subsequent multiply 3x4 gives lo=12, hi=0 in cycle 33.
